// File: rtl/seat_alloc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seat_alloc_pkg
//  Purpose  : Shared widths, batch capacity and collector state encoding for
//             the seat allocator front end (choice_collector) and the
//             allocator that consumes n / c1..c7.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package seat_alloc_pkg;

    localparam int CHOICE_W = 4;   // width of one choice code
    localparam int CNT_W    = 4;   // width of the candidate count n
    localparam int MAX_CAND = 7;   // batch capacity, legal range 1..7

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } coll_state_e;

endpackage
`default_nettype wire

// File: rtl/choice_slot_bank.sv
`default_nettype none
// ============================================================================
//  Module   : choice_slot_bank
//  Purpose  : N_SLOTS choice registers written one at a time by index, with a
//             synchronous clear of every slot. Always presents seven slots;
//             slots at index >= N_SLOTS read as zero.
//  Ports    : clk, rst        clock / asynchronous active-high reset
//             i_clear         clear all slots on the next rising edge
//             i_wr_en         write i_wr_data into slot i_wr_idx
//             i_wr_idx        slot index to write
//             i_wr_data       choice code to store
//             o_slots         seven slot values, o_slots[0] = first candidate
//  Revision : 1.0 - initial release
// ============================================================================
module choice_slot_bank
    import seat_alloc_pkg::*;
#(
    parameter int N_SLOTS = MAX_CAND,
    parameter int W       = CHOICE_W,
    parameter int IDX_W   = CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_wr_en,
    input  logic [IDX_W-1:0]     i_wr_idx,
    input  logic [W-1:0]         i_wr_data,
    output logic [6:0][W-1:0]    o_slots
);

    for (genvar i = 0; i < 7; i++) begin : g_slot
        if (i < N_SLOTS) begin : g_live
            logic [W-1:0] r_slot;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_slot <= '0;
                end else if (i_clear) begin
                    r_slot <= '0;
                end else if (i_wr_en && (i_wr_idx == IDX_W'(i))) begin
                    r_slot <= i_wr_data;
                end
            end

            assign o_slots[i] = r_slot;
        end else begin : g_unused
            assign o_slots[i] = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/choice_collector.sv
`default_nettype none
// ============================================================================
//  Module   : choice_collector
//  Purpose  : Collects seat-choice codes over a valid/ready handshake into a
//             batch of up to MAX_CAND entries (arrival order), then presents
//             the batch in parallel on n / c1..c7 with out_valid/out_ready.
//             A batch closes on in_last or when it reaches MAX_CAND entries.
//  Config   : ZERO_CHOICE_REJECT_EN - when defined, zero choice codes are
//             consumed but not stored, and err pulses for one cycle.
//  Ports    : clk, rst            clock / asynchronous active-high reset
//             in_valid/in_ready   upstream entry handshake
//             in_choice, in_last  offered code and batch-close flag
//             out_valid/out_ready batch handshake towards the allocator
//             n, c1..c7           registered batch count and slot contents
//             err                 one-cycle reject pulse
//  Revision : 1.0 - initial release
// ============================================================================
module choice_collector
    import seat_alloc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CHOICE_W-1:0]  in_choice,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     n,
    output logic [CHOICE_W-1:0]  c1,
    output logic [CHOICE_W-1:0]  c2,
    output logic [CHOICE_W-1:0]  c3,
    output logic [CHOICE_W-1:0]  c4,
    output logic [CHOICE_W-1:0]  c5,
    output logic [CHOICE_W-1:0]  c6,
    output logic [CHOICE_W-1:0]  c7,
    output logic                 err
);

    coll_state_e                r_state;
    coll_state_e                w_state_nxt;
    logic [CNT_W-1:0]           r_count;
    logic [CNT_W-1:0]           w_count_nxt;
    logic [CNT_W-1:0]           w_count_inc;
    logic                       r_err;
    logic                       w_accept;
    logic                       w_reject;
    logic                       w_store;
    logic                       w_handoff;
    logic [6:0][CHOICE_W-1:0]   w_slots;

    assign w_accept    = in_valid && (r_state == COLLECT);
`ifdef ZERO_CHOICE_REJECT_EN
    assign w_reject    = w_accept && (in_choice == '0);
`else
    assign w_reject    = 1'b0;
`endif
    assign w_store     = w_accept && !w_reject;
    assign w_handoff   = (r_state == PRESENT) && out_ready;
    assign w_count_inc = r_count + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            COLLECT: begin
                if (w_store) begin
                    w_count_nxt = w_count_inc;
                end
                // A rejected entry may still close the batch on in_last,
                // but only if something was stored before it.
                if (w_accept &&
                    ((in_last && (w_store || (r_count != '0))) ||
                     (w_store && (w_count_inc == CNT_W'(MAX_CAND))))) begin
                    w_state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    w_state_nxt = COLLECT;
                    w_count_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = COLLECT;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= COLLECT;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_err   <= w_reject;
        end
    end

    choice_slot_bank #(
        .N_SLOTS (MAX_CAND),
        .W       (CHOICE_W),
        .IDX_W   (CNT_W)
    ) u_slot_bank (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_handoff),
        .i_wr_en   (w_store),
        .i_wr_idx  (r_count),
        .i_wr_data (in_choice),
        .o_slots   (w_slots)
    );

    assign in_ready  = (r_state == COLLECT);
    assign out_valid = (r_state == PRESENT);
    assign n         = r_count;
    assign err       = r_err;
    assign c1        = w_slots[0];
    assign c2        = w_slots[1];
    assign c3        = w_slots[2];
    assign c4        = w_slots[3];
    assign c5        = w_slots[4];
    assign c6        = w_slots[5];
    assign c7        = w_slots[6];

endmodule
`default_nettype wire

// File: tb/tb_choice_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_choice_collector
//  Purpose  : Self-checking bench for choice_collector: directed scenarios and
//             random traffic compared every cycle against a queue-based model.
//  Config   : ZERO_CHOICE_REJECT_EN selects the matching model behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_choice_collector;
    import seat_alloc_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [CHOICE_W-1:0] in_choice;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [CNT_W-1:0]    n;
    logic [CHOICE_W-1:0] c1, c2, c3, c4, c5, c6, c7;
    logic                err;

    int checks = 0;
    int errors = 0;

    // Reference model: the batch is a queue of stored codes.
    int q[$];
    bit m_present;
    bit m_err;

    choice_collector dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_choice (in_choice),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n         (n),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .c4        (c4),
        .c5        (c5),
        .c6        (c6),
        .c7        (c7),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [CHOICE_W-1:0] c_at(input int i);
        case (i)
            0: return c1;
            1: return c2;
            2: return c3;
            3: return c4;
            4: return c5;
            5: return c6;
            default: return c7;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, " out_valid"}, 32'(out_valid), 32'(m_present));
        chk({where, " in_ready"}, 32'(in_ready), 32'(!m_present));
        chk({where, " n"}, 32'(n), 32'(q.size()));
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("%s c%0d", where, i + 1), 32'(c_at(i)),
                (i < q.size()) ? 32'(q[i]) : 32'd0);
        end
        chk({where, " err"}, 32'(err), 32'(m_err));
    endtask

    task automatic model_edge(input bit v, input int ch, input bit l, input bit ordy);
        m_err = 1'b0;
        if (!m_present) begin
            if (v) begin
`ifdef ZERO_CHOICE_REJECT_EN
                if (ch == 0) m_err = 1'b1;
                else         q.push_back(ch);
`else
                q.push_back(ch);
`endif
                if ((l && q.size() > 0) || q.size() == MAX_CAND) m_present = 1'b1;
            end
        end else if (ordy) begin
            q.delete();
            m_present = 1'b0;
        end
    endtask

    task automatic step(input bit v, input int ch, input bit l, input bit ordy, input string tag);
        in_valid  = v;
        in_choice = CHOICE_W'(ch);
        in_last   = l;
        out_ready = ordy;
        @(posedge clk);
        model_edge(v, ch, l, ordy);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset asserted between clock edges, checked before the next edge.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        m_present = 1'b0;
        m_err     = 1'b0;
        check_all(tag);
        chk({tag, " n zero"}, 32'(n), 32'd0);
        chk({tag, " in_ready one"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int t2_vals[7];
        t2_vals = '{15, 3, 7, 15, 7, 4, 7};
        rst = 1'b1; in_valid = 1'b0; in_choice = '0; in_last = 1'b0; out_ready = 1'b0;
        m_present = 1'b0; m_err = 1'b0;
        #3;
        check_all("por");
        @(negedge clk);
        rst = 1'b0;

        // 1. reset mid-batch
        step(1, 5, 0, 0, "t1 e1");
        step(1, 6, 0, 0, "t1 e2");
        step(1, 7, 0, 0, "t1 e3");
        chk("t1 n before reset", 32'(n), 32'd3);
        do_reset("t1 reset");

        // 2. full batch, in_last on the 7th
        for (int i = 0; i < 7; i++) step(1, t2_vals[i], (i == 6), 0, "t2 fill");
        chk("t2 out_valid", 32'(out_valid), 32'd1);
        chk("t2 n", 32'(n), 32'd7);
        chk("t2 c1", 32'(c1), 32'hF);
        chk("t2 c6", 32'(c6), 32'h4);
        chk("t2 c7", 32'(c7), 32'h7);
        step(0, 0, 0, 1, "t2 handoff");

        // 3. held presentation, then handoff
        step(1, 2, 0, 0, "t3 e1");
        step(1, 5, 0, 0, "t3 e2");
        step(1, 9, 1, 0, "t3 e3");
        for (int k = 0; k < 5; k++) step(1, 12, 0, 0, "t3 hold");
        chk("t3 c3", 32'(c3), 32'h9);
        chk("t3 c4", 32'(c4), 32'h0);
        step(0, 0, 0, 1, "t3 handoff");
        chk("t3 after c1", 32'(c1), 32'h0);
        chk("t3 after in_ready", 32'(in_ready), 32'd1);

        // 4. nine entries, no in_last: auto-close, 8th stalls
        for (int i = 0; i < 7; i++) step(1, i + 1, 0, 0, "t4 fill");
        chk("t4 autoclose n", 32'(n), 32'd7);
        for (int k = 0; k < 3; k++) step(1, 8, 0, 0, "t4 stall");
        step(1, 8, 0, 1, "t4 handoff");
        step(1, 8, 0, 0, "t4 e8");
        chk("t4 e8 is c1", 32'(c1), 32'h8);
        step(1, 9, 1, 0, "t4 e9");
        step(0, 0, 0, 1, "t4 handoff2");

        // 5. single entry batch
        step(1, 6, 1, 0, "t5 e1");
        chk("t5 n", 32'(n), 32'd1);
        chk("t5 c1", 32'(c1), 32'h6);
        step(0, 0, 0, 1, "t5 handoff");

        // 6. zero codes
        step(1, 0, 0, 0, "t6 e1");
        step(1, 4, 0, 0, "t6 e2");
        step(1, 0, 1, 0, "t6 e3");
`ifdef ZERO_CHOICE_REJECT_EN
        chk("t6 n", 32'(n), 32'd1);
        chk("t6 c1", 32'(c1), 32'h4);
`else
        chk("t6 n", 32'(n), 32'd3);
        chk("t6 c2", 32'(c2), 32'h4);
`endif
        step(0, 0, 0, 1, "t6 handoff");

        // Random traffic with one reset in the middle
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0), "rand");
            if (k == 200) do_reset("rand reset");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
